seq_divider: RTL

- Iterative unsigned restoring divider for the multiplier-check datapath; the inverse operation of the multiply path.
- Checks products by dividing them back down.
- Retires one quotient bit per clock.
- Each trial subtraction is an add of the inverted divisor with carry-in = 1.
- Start/busy/done handshake toward the check controller.

---
 rtl/seq_divider_pkg.sv | 20 ++
 rtl/seq_divider_div_trial_sub.sv | 33 +++
 rtl/seq_divider.sv | 132 +++++++++++++
 3 files changed

// File: rtl/seq_divider_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : seq_divider_pkg                                             |
// | Brief  : Shared constants for the sequential divider: default        |
// |          operand width, iteration counter width, FSM encoding.       |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package seq_divider_pkg;

   // Operand width is shared with the multiply/ALU datapath.
   localparam int DEF_MBITS = 12;
   // Iteration counter width; 2**DEF_CNTW must exceed DEF_MBITS.
   localparam int DEF_CNTW  = 4;

   // FSM encoding
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

endpackage : seq_divider_pkg
`default_nettype wire

// File: rtl/seq_divider_div_trial_sub.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : seq_divider_div_trial_sub                                   |
// | Brief  : Trial subtractor for the restoring divider. Computes        |
// |          rem - div at MBITS+1 bits as rem + ~{0,div} + 1.            |
// | Ports  : rem   in  MBITS+1  shifted partial remainder                |
// |          div   in  MBITS    divisor                                  |
// |          diff  out MBITS    low bits of the difference               |
// |          sign  out 1        1 when the difference is negative        |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module seq_divider_div_trial_sub #(
   parameter int MBITS = 12
) (
   input  logic [MBITS:0]   rem,
   input  logic [MBITS-1:0] div,
   output logic [MBITS-1:0] diff,
   output logic             sign
);

   logic [MBITS:0] div_inv;
   logic [MBITS:0] sum;

   // Divisor is zero-extended before inversion so the carry-in of one
   // produces a true two's-complement negation at MBITS+1 bits.
   assign div_inv = ~{1'b0, div};
   assign sum     = rem + div_inv + {{MBITS{1'b0}}, 1'b1};

   assign diff = sum[MBITS-1:0];
   assign sign = sum[MBITS];

endmodule : seq_divider_div_trial_sub
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : seq_divider                                                 |
// | Brief  : Iterative unsigned restoring divider, one quotient bit per  |
// |          clock, start/busy/done handshake.                           |
// | Ports  : clk, reset (sync, active high)                              |
// |          start, dividend, divisor        request + operands          |
// |          busy, done                      handshake status            |
// |          quotient, remainder, div_by_zero registered results         |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int MBITS = DEF_MBITS,
   parameter int CNTW  = DEF_CNTW
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [MBITS-1:0] dividend,
   input  logic [MBITS-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [MBITS-1:0] quotient,
   output logic [MBITS-1:0] remainder,
   output logic             div_by_zero
);

   logic [0:0]       state_q,       state_d;
   logic [MBITS-1:0] r_q,           r_d;
   logic [MBITS-1:0] q_q,           q_d;
   logic [MBITS-1:0] d_q,           d_d;
   logic [CNTW-1:0]  cnt_q,         cnt_d;
   logic             done_q,        done_d;
   logic             dbz_q,         dbz_d;
   logic [MBITS-1:0] quotient_q,    quotient_d;
   logic [MBITS-1:0] remainder_q,   remainder_d;

   logic [MBITS:0]   rs;
   logic [MBITS-1:0] trial_diff;
   logic             trial_sign;
   logic [MBITS-1:0] next_r;
   logic [MBITS-1:0] next_q;

   // The restored remainder is always below the divisor, so MBITS bits
   // hold it; only the shifted value needs the extra top bit.
   assign rs = {r_q, q_q[MBITS-1]};

   seq_divider_div_trial_sub #(
      .MBITS (MBITS)
   ) u_trial_sub (
      .rem  (rs),
      .div  (d_q),
      .diff (trial_diff),
      .sign (trial_sign)
   );

   always_comb begin
      next_r = trial_sign ? rs[MBITS-1:0] : trial_diff;
      next_q = {q_q[MBITS-2:0], ~trial_sign};
   end

   always_comb begin
      state_d     = state_q;
      r_d         = r_q;
      q_d         = q_q;
      d_d         = d_q;
      cnt_d       = cnt_q;
      done_d      = 1'b0;
      dbz_d       = dbz_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               q_d     = dividend;
               r_d     = '0;
               d_d     = divisor;
               cnt_d   = '0;
               dbz_d   = (divisor == '0);
               state_d = RUN;
            end
         end
         RUN: begin
            r_d   = next_r;
            q_d   = next_q;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNTW'(MBITS - 1)) begin
               quotient_d  = next_q;
               remainder_d = next_r;
               done_d      = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         r_q         <= '0;
         q_q         <= '0;
         d_q         <= '0;
         cnt_q       <= '0;
         done_q      <= 1'b0;
         dbz_q       <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
      end else begin
         state_q     <= state_d;
         r_q         <= r_d;
         q_q         <= q_d;
         d_q         <= d_d;
         cnt_q       <= cnt_d;
         done_q      <= done_d;
         dbz_q       <= dbz_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
      end
   end

   assign busy        = (state_q == RUN);
   assign done        = done_q;
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dbz_q;

endmodule : seq_divider
`default_nettype wire
